alu_mdu: RTL

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with an optional iterative multiply/divide unit.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   InValid / InReady    request handshake; SrcA, SrcB, ALUControl captured on accept
//   OutValid / OutReady  result handshake; result held until taken
//   ALUResult            registered result
//   Zero, Negative       flags derived from the registered result
//   Illegal              held result came from an unsupported ALUControl code
//
// Build option: define ALU_MDU_EN to include the shift-add multiplier and restoring
// divider (MUL, MULHU, DIV, DIVU, REM, REMU). Without it those codes are illegal.
module alu_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [4:0]      ALUControl,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Negative,
    output logic            Illegal
);

    localparam logic [4:0] OpSll   = 5'b00000;
    localparam logic [4:0] OpSrl   = 5'b10000;
    localparam logic [4:0] OpSra   = 5'b10001;
    localparam logic [4:0] OpAdd   = 5'b00010;
    localparam logic [4:0] OpSub   = 5'b11110;
    localparam logic [4:0] OpOr    = 5'b00111;
    localparam logic [4:0] OpAnd   = 5'b00011;
    localparam logic [4:0] OpXor   = 5'b00100;
    localparam logic [4:0] OpSlt   = 5'b00101;
    localparam logic [4:0] OpSltu  = 5'b00110;
`ifdef ALU_MDU_EN
    localparam logic [4:0] OpMul   = 5'b01000;
    localparam logic [4:0] OpMulhu = 5'b01001;
    localparam logic [4:0] OpDiv   = 5'b01100;
    localparam logic [4:0] OpDivu  = 5'b01101;
    localparam logic [4:0] OpRem   = 5'b01110;
    localparam logic [4:0] OpRemu  = 5'b01111;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_legal;
    logic            start_calc;

    assign shamt = SrcB[SHW-1:0];

`ifdef ALU_MDU_EN
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            is_mul, is_div, is_signed;
    logic            a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_mul    = (ALUControl == OpMul) || (ALUControl == OpMulhu);
    assign is_div    = (ALUControl == OpDiv) || (ALUControl == OpDivu) ||
                       (ALUControl == OpRem) || (ALUControl == OpRemu);
    assign is_signed = (ALUControl == OpDiv) || (ALUControl == OpRem);
    assign a_neg     = is_signed & SrcA[XLEN-1];
    assign b_neg     = is_signed & SrcB[XLEN-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;
    assign div_zero  = (SrcB == '0);
    assign overflow  = is_signed && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    // Divide-by-zero and signed overflow finish in one cycle through the ALU path.
    assign start_calc = is_mul || (is_div && !div_zero && !overflow);

    // One iteration of the shift-add multiplier: {hi, lo} holds partial product and
    // the not-yet-consumed multiplier bits.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    // One iteration of the restoring divider: hi = partial remainder, lo shifts the
    // dividend out and the quotient bits in.
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_hi, div_lo;
    assign rem_sh = {hi_q, lo_q[XLEN-1]};
    assign div_ge = rem_sh >= {1'b0, mcand_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
    assign div_hi = div_ge ? (rem_sh[XLEN-1:0] - mcand_q) : rem_sh[XLEN-1:0];
    assign div_lo = {lo_q[XLEN-2:0], div_ge};

    logic            op_is_mul;
    logic [XLEN-1:0] step_hi, step_lo, mdu_res;
    assign op_is_mul = (op_q == OpMul) || (op_q == OpMulhu);
    assign step_hi   = op_is_mul ? mul_hi : div_hi;
    assign step_lo   = op_is_mul ? mul_lo : div_lo;

    always_comb begin
        mdu_res = '0;
        case (op_q)
            OpMul:   mdu_res = step_lo;
            OpMulhu: mdu_res = step_hi;
            OpDiv:   mdu_res = qneg_q ? -step_lo : step_lo;
            OpDivu:  mdu_res = step_lo;
            OpRem:   mdu_res = rneg_q ? -step_hi : step_hi;
            OpRemu:  mdu_res = step_hi;
            default: mdu_res = '0;
        endcase
    end
`else
    assign start_calc = 1'b0;
`endif

    // Single-cycle results, including the multi-cycle bypass cases.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (ALUControl)
            OpSll:  alu_res = SrcA << shamt;
            OpSrl:  alu_res = SrcA >> shamt;
            OpSra:  alu_res = $signed(SrcA) >>> shamt;
            OpAdd:  alu_res = SrcA + SrcB;
            OpSub:  alu_res = SrcA - SrcB;
            OpOr:   alu_res = SrcA | SrcB;
            OpAnd:  alu_res = SrcA & SrcB;
            OpXor:  alu_res = SrcA ^ SrcB;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, SrcA < SrcB};
`ifdef ALU_MDU_EN
            OpMul, OpMulhu: alu_res = '0;
            // Bypass values: div-by-zero gives all-ones, overflow gives A.
            OpDiv, OpDivu:  alu_res = div_zero ? '1 : SrcA;
            OpRem, OpRemu:  alu_res = div_zero ? SrcA : '0;
`endif
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MDU_EN
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            StIdle: begin
                if (InValid) begin
                    if (start_calc) begin
`ifdef ALU_MDU_EN
                        op_d    = ALUControl;
                        hi_d    = '0;
                        lo_d    = is_mul ? SrcA : a_mag;
                        mcand_d = is_mul ? SrcB : b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
`endif
                        state_d = StCalc;
                    end else begin
                        result_d  = alu_res;
                        illegal_d = !alu_legal;
                        state_d   = StDone;
                    end
                end
            end
            StCalc: begin
`ifdef ALU_MDU_EN
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(XLEN - 1)) begin
                    result_d  = mdu_res;
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (OutReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_MDU_EN
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef ALU_MDU_EN
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign InReady   = (state_q == StIdle);
    assign OutValid  = (state_q == StDone);
    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign Negative  = result_q[XLEN-1];
    assign Illegal   = illegal_q;

endmodule
